// File: rtl/ray_scene_scheduler_if.sv
// Handshake and bus bundle for ray_scene_scheduler.
//   ray_*   : ray request from the per-pixel generator (valid/ready)
//   obj_*   : synchronous object memory read port (1-cycle latency)
//   trc_*   : drive/return of the sphere-intersection datapath
//   res_*   : nearest-hit result to the framebuffer writer (valid/ready)
//   busy    : scheduler not idle
// Optional macro RT_ANY_HIT_EN adds ray_any (shadow-ray any-hit request).
// Modport slave is the scheduler's view; master is the surrounding system.
interface ray_scene_scheduler_if #(
    parameter int unsigned OBJ_AW = 4
);
    logic              ray_valid;
    logic              ray_ready;
    logic [27:0]       ray_init;
    logic [30:0]       ray_dir;
    logic [OBJ_AW:0]   obj_count;
`ifdef RT_ANY_HIT_EN
    logic              ray_any;
`endif
    logic [OBJ_AW-1:0] obj_addr;
    logic [47:0]       obj_data;
    logic [27:0]       trc_init;
    logic [30:0]       trc_dir;
    logic [47:0]       trc_object;
    logic [9:0]        trc_t;
    logic              res_valid;
    logic              res_ready;
    logic              res_hit;
    logic [9:0]        res_t;
    logic [11:0]       res_color;
    logic [OBJ_AW-1:0] res_obj;
    logic              busy;

`ifdef RT_ANY_HIT_EN
    modport slave (
        input  ray_valid, ray_init, ray_dir, obj_count, ray_any, obj_data, trc_t, res_ready,
        output ray_ready, obj_addr, trc_init, trc_dir, trc_object,
        output res_valid, res_hit, res_t, res_color, res_obj, busy
    );
    modport master (
        output ray_valid, ray_init, ray_dir, obj_count, ray_any, obj_data, trc_t, res_ready,
        input  ray_ready, obj_addr, trc_init, trc_dir, trc_object,
        input  res_valid, res_hit, res_t, res_color, res_obj, busy
    );
`else
    modport slave (
        input  ray_valid, ray_init, ray_dir, obj_count, obj_data, trc_t, res_ready,
        output ray_ready, obj_addr, trc_init, trc_dir, trc_object,
        output res_valid, res_hit, res_t, res_color, res_obj, busy
    );
    modport master (
        output ray_valid, ray_init, ray_dir, obj_count, obj_data, trc_t, res_ready,
        input  ray_ready, obj_addr, trc_init, trc_dir, trc_object,
        input  res_valid, res_hit, res_t, res_color, res_obj, busy
    );
`endif
endinterface

// File: rtl/ray_scene_scheduler.sv
// ray_scene_scheduler: runs one ray against every sphere in object memory through a single
// shared intersection datapath and keeps the nearest valid hit.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : ray_scene_scheduler_if.slave (ray request, object memory, tracer, result, busy)
// Parameters: OBJ_AW (object address width), TRACE_LAT (tracer latency, 0 = combinational),
//   BG_COLOR (colour reported on a miss).
// Optional macro RT_ANY_HIT_EN: adds ray_any; the first hit stops issue and is reported.
module ray_scene_scheduler #(
    parameter int unsigned OBJ_AW    = 4,
    parameter int unsigned TRACE_LAT = 1,
    parameter logic [11:0] BG_COLOR  = 12'h000
) (
    input logic                 clk,
    input logic                 rst,
    ray_scene_scheduler_if.slave bus
);
    // One stage for the memory read plus the tracer latency.
    localparam int unsigned     Depth    = TRACE_LAT + 1;
    localparam logic [9:0]      TMiss    = 10'h3FF;
    localparam logic [OBJ_AW:0] MaxCount = (OBJ_AW + 1)'(1) << OBJ_AW;
    localparam logic [OBJ_AW:0] CntOne   = (OBJ_AW + 1)'(1);
    localparam logic [OBJ_AW-1:0] AddrOne = OBJ_AW'(1);

    typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

    state_e                       state_q, state_d;
    logic [27:0]                  ray_init_q;
    logic [30:0]                  ray_dir_q;
    logic [OBJ_AW:0]              count_q, count_sat;
    logic [OBJ_AW-1:0]            addr_q, addr_d;
    logic [Depth-1:0]             tag_v_q;
    logic [Depth-1:0][OBJ_AW-1:0] tag_idx_q;
    logic                         push, pending, accept, last_issue;
    logic                         cmp_valid, cmp_hit, better, update, stop_set;
    logic [OBJ_AW-1:0]            cmp_idx;
    logic [11:0]                  cmp_col;
    logic                         best_hit_q;
    logic [9:0]                   best_t_q;
    logic [OBJ_AW-1:0]            best_obj_q;
    logic [11:0]                  best_color_q;

    assign accept     = bus.ray_valid && (state_q == StIdle);
    assign count_sat  = (bus.obj_count > MaxCount) ? MaxCount : bus.obj_count;
    assign last_issue = ({1'b0, addr_q} == (count_q - CntOne));

    assign cmp_valid = tag_v_q[Depth-1];
    assign cmp_idx   = tag_idx_q[Depth-1];
    assign cmp_hit   = cmp_valid && (bus.trc_t != TMiss);
    // Strict less-than: on equal t the earlier (lower) index is kept.
    assign better    = cmp_hit && (bus.trc_t < best_t_q);

    // Colour rides alongside the tag, captured once obj_data is valid (one cycle after issue).
    if (TRACE_LAT == 0) begin : g_col_direct
        assign cmp_col = bus.obj_data[47:36];
    end else begin : g_col_pipe
        logic [TRACE_LAT-1:0][11:0] col_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                col_q <= '0;
            end else begin
                col_q[0] <= bus.obj_data[47:36];
                for (int i = 1; i < int'(TRACE_LAT); i++) begin
                    col_q[i] <= col_q[i-1];
                end
            end
        end
        assign cmp_col = col_q[TRACE_LAT-1];
    end

`ifdef RT_ANY_HIT_EN
    logic any_q, stop_q;
    assign stop_set = any_q && cmp_hit && !stop_q;
    // Once stopped, draining tags must not replace the first recorded hit.
    assign update   = better && !stop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_q  <= 1'b0;
            stop_q <= 1'b0;
        end else if (accept) begin
            any_q  <= bus.ray_any;
            stop_q <= 1'b0;
        end else if (stop_set) begin
            stop_q <= 1'b1;
        end
    end
`else
    assign stop_set = 1'b0;
    assign update   = better;
`endif

    // Tags still in flight, excluding the output stage which leaves this cycle.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < int'(Depth) - 1; i++) begin
            pending = pending | tag_v_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        push    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.ray_valid) begin
                    addr_d  = '0;
                    state_d = (count_sat == '0) ? StDone : StScan;
                end
            end
            StScan: begin
                if (stop_set) begin
                    state_d = StDrain;
                end else begin
                    push = 1'b1;
                    if (last_issue) begin
                        state_d = StDrain;
                    end else begin
                        addr_d = addr_q + AddrOne;
                    end
                end
            end
            StDrain: begin
                if (!pending) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            ray_init_q <= '0;
            ray_dir_q  <= '0;
            count_q    <= '0;
            tag_v_q    <= '0;
            tag_idx_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            if (accept) begin
                ray_init_q <= bus.ray_init;
                ray_dir_q  <= bus.ray_dir;
                count_q    <= count_sat;
            end
            tag_v_q[0]   <= push;
            tag_idx_q[0] <= addr_q;
            for (int i = 1; i < int'(Depth); i++) begin
                tag_v_q[i]   <= tag_v_q[i-1];
                tag_idx_q[i] <= tag_idx_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_hit_q   <= 1'b0;
            best_t_q     <= TMiss;
            best_obj_q   <= '0;
            best_color_q <= BG_COLOR;
        end else if (accept) begin
            best_hit_q   <= 1'b0;
            best_t_q     <= TMiss;
            best_obj_q   <= '0;
            best_color_q <= BG_COLOR;
        end else if (update) begin
            best_hit_q   <= 1'b1;
            best_t_q     <= bus.trc_t;
            best_obj_q   <= cmp_idx;
            best_color_q <= cmp_col;
        end
    end

    assign bus.ray_ready  = (state_q == StIdle);
    assign bus.busy       = (state_q != StIdle);
    assign bus.obj_addr   = addr_q;
    assign bus.trc_init   = ray_init_q;
    assign bus.trc_dir    = ray_dir_q;
    assign bus.trc_object = bus.obj_data;
    assign bus.res_valid  = (state_q == StDone);
    assign bus.res_hit    = best_hit_q;
    assign bus.res_t      = best_t_q;
    assign bus.res_color  = best_color_q;
    assign bus.res_obj    = best_obj_q;
endmodule

// File: tb/tb_ray_scene_scheduler.sv
// Self-checking bench for ray_scene_scheduler: models object memory and a 1-cycle tracer
// (t taken from centre[9:0]), pushes expected results to a scoreboard queue on each ray
// and compares when the result handshake occurs.
module tb_ray_scene_scheduler;
    localparam int unsigned ObjAw    = 4;
    localparam int unsigned TraceLat = 1;
    localparam logic [11:0] BgColor  = 12'h123;

    typedef struct {
        logic        hit;
        logic [9:0]  t;
        logic [11:0] color;
        logic [3:0]  obj;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          errors = 0;
    logic [47:0] obj_mem [16];
    exp_t        exp_q [$];
    logic        track_addr = 1'b0;
    logic [3:0]  max_addr;

    ray_scene_scheduler_if #(.OBJ_AW(ObjAw)) bus_if ();

    ray_scene_scheduler #(
        .OBJ_AW   (ObjAw),
        .TRACE_LAT(TraceLat),
        .BG_COLOR (BgColor)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    // Synchronous object memory and a one-cycle tracer stand-in.
    always @(posedge clk) begin
        bus_if.obj_data <= obj_mem[bus_if.obj_addr];
        bus_if.trc_t    <= bus_if.trc_object[9:0];
    end

    always @(negedge clk) begin
        if (!track_addr) max_addr = '0;
        else if (bus_if.busy && bus_if.obj_addr > max_addr) max_addr = bus_if.obj_addr;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic set_obj(input int i, input logic [9:0] t, input logic [11:0] col);
        obj_mem[i] = {col, 8'h10, 18'h0, t};
    endtask

    function automatic exp_t model(input int n, input bit any);
        exp_t e;
        logic [9:0] t;
        e.hit = 1'b0; e.t = 10'h3FF; e.color = BgColor; e.obj = '0;
        e.lat = any ? -1 : ((n == 0) ? 1 : n + 2 + int'(TraceLat));
        for (int i = 0; i < n; i++) begin
            t = obj_mem[i][9:0];
            if (t != 10'h3FF && t < e.t && !(any && e.hit)) begin
                e.hit = 1'b1; e.t = t; e.color = obj_mem[i][47:36]; e.obj = 4'(i);
            end
        end
        return e;
    endfunction

    task automatic check_reset(input string tag);
        check_eq({tag, "_ray_ready"}, bus_if.ray_ready, 1'b1);
        check_eq({tag, "_res_valid"}, bus_if.res_valid, 1'b0);
        check_eq({tag, "_res_hit"}, bus_if.res_hit, 1'b0);
        check_eq({tag, "_res_t"}, bus_if.res_t, 10'h3FF);
        check_eq({tag, "_res_color"}, bus_if.res_color, BgColor);
        check_eq({tag, "_res_obj"}, bus_if.res_obj, 4'd0);
        check_eq({tag, "_obj_addr"}, bus_if.obj_addr, 4'd0);
        check_eq({tag, "_busy"}, bus_if.busy, 1'b0);
    endtask

    task automatic run_ray(input logic [4:0] cnt, input bit any, input int hold);
        int          n;
        int          cyc;
        exp_t        e;
        logic [27:0] ri;
        logic [30:0] rd;
        n  = (cnt > 5'd16) ? 16 : int'(cnt);
        ri = 28'($urandom);
        rd = 31'($urandom);
        exp_q.push_back(model(n, any));
        bus_if.ray_init  = ri;
        bus_if.ray_dir   = rd;
        bus_if.obj_count = cnt;
`ifdef RT_ANY_HIT_EN
        bus_if.ray_any   = any;
`endif
        bus_if.ray_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.ray_valid = 1'b0;
        cyc = 1;
        check_eq("trc_init", bus_if.trc_init, ri);
        check_eq("trc_dir", bus_if.trc_dir, rd);
        while (!bus_if.res_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("res_valid_seen", bus_if.res_valid, 1'b1);
        e = exp_q.pop_front();
        if (e.lat >= 0) check_eq("latency", cyc, e.lat);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check_eq("hold_valid", bus_if.res_valid, 1'b1);
            check_eq("hold_ray_ready", bus_if.ray_ready, 1'b0);
            check_eq("hold_t", bus_if.res_t, e.t);
            check_eq("hold_color", bus_if.res_color, e.color);
        end
        bus_if.res_ready = 1'b1;
        check_eq("res_hit", bus_if.res_hit, e.hit);
        check_eq("res_t", bus_if.res_t, e.t);
        check_eq("res_color", bus_if.res_color, e.color);
        check_eq("res_obj", bus_if.res_obj, e.obj);
        @(posedge clk); #1;
        bus_if.res_ready = 1'b0;
        check_eq("back_idle", bus_if.ray_ready, 1'b1);
        check_eq("valid_drop", bus_if.res_valid, 1'b0);
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        bus_if.ray_valid = 1'b0;
        bus_if.ray_init  = '0;
        bus_if.ray_dir   = '0;
        bus_if.obj_count = '0;
        bus_if.res_ready = 1'b0;
`ifdef RT_ANY_HIT_EN
        bus_if.ray_any   = 1'b0;
`endif
        for (int i = 0; i < 16; i++) set_obj(i, 10'h3FF, 12'h000);
        repeat (2) @(posedge clk);
        #1;
        check_reset("por");
        rst = 1'b0;
        @(posedge clk); #1;

        // Nearest of 200, 50, miss.
        set_obj(0, 10'd200, 12'hF00);
        set_obj(1, 10'd50, 12'h0F0);
        set_obj(2, 10'h3FF, 12'h00F);
        run_ray(5'd3, 1'b0, 0);
        check_eq("trc_object_pass", bus_if.trc_object, bus_if.obj_data);

        // All misses.
        for (int i = 0; i < 4; i++) set_obj(i, 10'h3FF, 12'hABC);
        run_ray(5'd4, 1'b0, 0);

        // Tie keeps the lower index.
        set_obj(0, 10'd120, 12'h111);
        set_obj(1, 10'd120, 12'h222);
        run_ray(5'd2, 1'b0, 0);

        // Empty scene, result held while res_ready is low.
        run_ray(5'd0, 1'b0, 5);

        // Abort mid-scan with reset.
        for (int i = 0; i < 8; i++) set_obj(i, 10'(20 + i), 12'(i));
        bus_if.obj_count = 5'd8;
        bus_if.ray_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.ray_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset("abort");
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus_if.res_valid) seen = 1'b1;
        end
        check_eq("no_result_after_abort", seen, 1'b0);

        set_obj(0, 10'd90, 12'h0AA);
        set_obj(1, 10'd40, 12'h0BB);
        run_ray(5'd2, 1'b0, 0);

        // Single object, full scene, saturated count and random scenes.
        run_ray(5'd1, 1'b0, 0);
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 16; i++) begin
                set_obj(i, ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom_range(0, 1022)),
                        12'($urandom));
            end
            if (r == 0) run_ray(5'd20, 1'b0, 1);
            else if (r == 1) run_ray(5'd16, 1'b0, 0);
            else run_ray(5'($urandom_range(1, 16)), 1'b0, 0);
        end

`ifdef RT_ANY_HIT_EN
        for (int i = 0; i < 16; i++) set_obj(i, 10'h3FF, 12'h000);
        set_obj(2, 10'd300, 12'hC0C);
        set_obj(5, 10'd10, 12'h505);
        track_addr = 1'b1;
        run_ray(5'd8, 1'b1, 0);
        track_addr = 1'b0;
        check_eq("anyhit_addr_stop", (max_addr <= 4'd4), 1'b1);
        run_ray(5'd8, 1'b0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
